// File: rtl/param_seq_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Imported by the detector top and its saturating counter.
package param_seq_pkg;

    localparam int DEF_PAT_W = 8;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 8'b0000_1011;
    localparam int DEF_LEN = 4;
    localparam int DEF_CNT_W = 8;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over increment.
// Used as the detector's match counter.
module sat_counter
    import param_seq_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up to all-ones and hold; a clear always returns to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Run-time programmable Mealy serial pattern detector with
// overlap control, zero-latency match flag and match counter.
module param_seq_detector
    import param_seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEF_PATTERN),
    parameter int DEFAULT_LEN = DEF_LEN,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_p1;
    logic             enough;
    logic             match;
    logic             len_ok;

    assign window  = {hist, in};
    assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    assign enough  = fill_p1 >= {1'b0, len};
    assign len_ok  = (len_in != '0) && (len_in <= LEN_W'(PAT_W));

    // Only the low len bits of the pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = LEN_W'(i) < len;
        end
    end

    // Match needs a qualified bit, no load this cycle and enough history.
    always_comb begin
        match = in_valid && !pat_load && !rst && enough
              && (((window ^ pat) & mask) == '0);
    end

    assign out = match;

    // Configuration, history shift register and illegal-load flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat     <= DEFAULT_PAT;
            len     <= LEN_W'(DEFAULT_LEN);
            hist    <= '0;
            fill    <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= pat_load && !len_ok;
            if (pat_load) begin
                if (len_ok) begin
                    pat  <= pat_in;
                    len  <= len_in;
                    hist <= '0;
                    fill <= '0;
                end
            end else if (in_valid) begin
                if (match && !overlap) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= window[PAT_W-2:0];
                    if (fill != LEN_W'(PAT_W - 1)) begin
                        fill <= fill + LEN_W'(1);
                    end
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector: expected match flags are
// queued as bits are driven and compared mid-cycle.
module tb_param_seq_detector;

    logic       clk;
    logic       rst;
    logic       din;
    logic       in_valid;
    logic       overlap;
    logic       pat_load;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       cnt_clr;

    logic       out;
    logic [7:0] match_cnt;
    logic       cfg_err;
    logic       out2;
    logic [1:0] match_cnt2;
    logic       cfg_err2;

    typedef struct {
        logic exp;
        int   idx;
    } sb_t;

    sb_t q[$];
    int  bitno = 0;
    int  total = 0;
    int  pass = 0;

    param_seq_detector dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (in_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .cnt_clr   (cnt_clr),
        .out       (out),
        .match_cnt (match_cnt),
        .cfg_err   (cfg_err)
    );

    param_seq_detector #(
        .CNT_W (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (in_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .cnt_clr   (cnt_clr),
        .out       (out2),
        .match_cnt (match_cnt2),
        .cfg_err   (cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop one expected flag per driven cycle, mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            sb_t e;
            e = q.pop_front();
            total++;
            if ({out, out2} !== {e.exp, e.exp})
                $display("FAIL out[%0d]: got %b/%b want %b",
                         e.idx, out, out2, e.exp);
            else
                pass++;
        end
    end

    task automatic drive(input logic v, input logic b, input logic exp);
        in_valid = v;
        din = b;
        q.push_back('{exp, bitno});
        bitno++;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l);
        pat_load = 1'b1;
        pat_in = p;
        len_in = l;
        cnt_clr = 1'b1;
        in_valid = 1'b1;
        din = 1'b1;
        q.push_back('{1'b0, bitno});
        bitno++;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        cnt_clr = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        in_valid = 1'b1;
        overlap = 1'b1;
        pat_load = 1'b0;
        pat_in = '0;
        len_in = '0;
        cnt_clr = 1'b0;
        #2;
        total++;
        if ({out, out2} !== 2'b00)
            $display("FAIL reset_out: got %b/%b want 0", out, out2);
        else
            pass++;
        total++;
        if ({match_cnt, match_cnt2, cfg_err} !== 11'd0)
            $display("FAIL reset_regs: cnt %0d cnt2 %0d err %b want 0",
                     match_cnt, match_cnt2, cfg_err);
        else
            pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001001;
        load(8'b0000_1011, 4'd4);
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) drive(1'b1, s[i], e[i]);
        total++;
        if (match_cnt !== 8'd2)
            $display("FAIL overlap_cnt: got %0d want 2", match_cnt);
        else
            pass++;
    endtask

    task automatic test_no_overlap();
        logic [10:0] s = 11'b101_1011_1011;
        logic [10:0] e = 11'b000_1000_0001;
        load(8'b0000_1011, 4'd4);
        overlap = 1'b0;
        for (int i = 10; i >= 0; i--) drive(1'b1, s[i], e[i]);
        total++;
        if (match_cnt !== 8'd2)
            $display("FAIL nonoverlap_cnt: got %0d want 2", match_cnt);
        else
            pass++;
    endtask

    task automatic test_gaps();
        load(8'b0000_0110, 4'd3);
        overlap = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        total++;
        if ({cfg_err, match_cnt} !== {1'b0, 8'd2})
            $display("FAIL gaps: err %b cnt %0d want 0/2", cfg_err, match_cnt);
        else
            pass++;
    endtask

    task automatic test_saturate();
        load(8'b0000_0001, 4'd1);
        overlap = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b1, 1'b1);
            total++;
            if (match_cnt2 !== 2'((k > 3) ? 3 : k))
                $display("FAIL sat_cnt2[%0d]: got %0d want %0d",
                         k, match_cnt2, (k > 3) ? 3 : k);
            else
                pass++;
            total++;
            if (match_cnt !== 8'(k))
                $display("FAIL sat_cnt[%0d]: got %0d want %0d",
                         k, match_cnt, k);
            else
                pass++;
        end
        cnt_clr = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        cnt_clr = 1'b0;
        total++;
        if ({match_cnt, match_cnt2} !== 10'd0)
            $display("FAIL clr_prio: got %0d/%0d want 0",
                     match_cnt, match_cnt2);
        else
            pass++;
    endtask

    task automatic test_bad_load();
        logic [3:0] s = 4'b1011;
        logic [3:0] e = 4'b0001;
        load(8'b0000_1011, 4'd4);
        total++;
        if (cfg_err !== 1'b0)
            $display("FAIL good_load_err: got %b want 0", cfg_err);
        else
            pass++;
        load(8'hff, 4'd0);
        total++;
        if (cfg_err !== 1'b1)
            $display("FAIL len0_err: got %b want 1", cfg_err);
        else
            pass++;
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (cfg_err !== 1'b0)
            $display("FAIL len0_pulse: got %b want 0", cfg_err);
        else
            pass++;
        load(8'hff, 4'd9);
        total++;
        if (cfg_err !== 1'b1)
            $display("FAIL len9_err: got %b want 1", cfg_err);
        else
            pass++;
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (cfg_err !== 1'b0)
            $display("FAIL len9_pulse: got %b want 0", cfg_err);
        else
            pass++;
        overlap = 1'b1;
        for (int i = 3; i >= 0; i--) drive(1'b1, s[i], e[i]);
    endtask

    task automatic test_mid_reset();
        logic [5:0] s = 6'b101101;
        logic [5:0] e = 6'b000100;
        logic [6:0] s2 = 7'b1111011;
        logic [6:0] e2 = 7'b0000001;
        load(8'b0000_1011, 4'd4);
        overlap = 1'b1;
        for (int i = 5; i >= 0; i--) drive(1'b1, s[i], e[i]);
        total++;
        if (match_cnt !== 8'd1)
            $display("FAIL pre_rst_cnt: got %0d want 1", match_cnt);
        else
            pass++;
        #2;
        rst = 1'b1;
        in_valid = 1'b1;
        din = 1'b1;
        #1;
        total++;
        if ({out, match_cnt} !== 9'd0)
            $display("FAIL async_rst: out %b cnt %0d want 0/0",
                     out, match_cnt);
        else
            pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 6; i >= 0; i--) drive(1'b1, s2[i], e2[i]);
        total++;
        if (match_cnt !== 8'd1)
            $display("FAIL post_rst_cnt: got %0d want 1", match_cnt);
        else
            pass++;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_gaps();
        test_saturate();
        test_bad_load();
        test_mid_reset();
        @(posedge clk);
        #1;
        total++;
        if (q.size() != 0)
            $display("FAIL sb_drain: %0d left want 0", q.size());
        else
            pass++;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
